// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor, one full-adder cell reused LSB first over WIDTH cycles
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [WIDTH-1:0] opa, opb, nxt;
  logic [WIDTH-2:0] sh;
  logic [CW-1:0]    cnt;
  logic             carry, s, cy;
  always_comb begin
    s   = opa[0] ^ opb[0] ^ carry;
    cy  = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
    nxt = {s, sh};
  end
  // DONE lasts one cycle; a start seen on its exit edge is taken so back-to-back ops run every WIDTH+1 cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      sh       <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (state == RUN) begin
      sh    <= nxt[WIDTH-1:1];
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      carry <= cy;
      cnt   <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        result   <= nxt;
        c_out    <= cy;
        overflow <= carry ^ cy;
        busy     <= 1'b0;
        done     <= 1'b1;
        state    <= DONE;
      end
    end else begin
      done <= 1'b0;
      if (start) begin
        opa   <= a;
        opb   <= sub ? ~b : b;
        carry <= sub;
        cnt   <= '0;
        busy  <= 1'b1;
        state <= RUN;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for serial_addsub with directed corner cases and randomised back-to-back ops
module tb_serial_addsub;
  logic       clk = 1'b0, rst, start, sub;
  logic [7:0] a, b, result;
  logic       busy, done, c_out, overflow;
  typedef struct packed {logic [7:0] r; logic c; logic o;} exp_t;
  exp_t sb[$];
  exp_t me;
  int   checks = 0, failures = 0;

  serial_addsub #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .c_out(c_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic s);
    exp_t e;
    int   sr;
    int   ur;
    ur  = s ? int'(x) + 256 - int'(y) : int'(x) + int'(y);
    sr  = s ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
    e.r = ur[7:0];
    e.c = ur >= 256;
    e.o = (sr > 127) || (sr < -128);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_done_exclusive", busy & done, 0);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done got=done want=no_done result=%0h at %0t", result, $time);
        end else begin
          me = sb.pop_front();
          chk("result", result, me.r);
          chk("c_out", c_out, me.c);
          chk("overflow", overflow, me.o);
        end
      end
    end
  end

  task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                    input logic [7:0] er, input logic ec, input logic eo);
    int n = 0, nb = 0;
    @(negedge clk);
    a = ia; b = ib; sub = is; start = 1'b1;
    sb.push_back({er, ec, eo});
    @(posedge clk);
    #1 start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    repeat (20) begin
      @(negedge clk);
      n++;
      if (done) break;
      nb += int'(busy);
    end
    chk("done_latency", n, 9);
    chk("busy_cycles", nb, 8);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #3;
    chk("rst_result", result, 0);
    chk("rst_flags", {busy, done, c_out, overflow}, 0);
    @(negedge clk) rst = 1'b0;
    op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0);
    op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    // a second start mid-run must be dropped, operand changes ignored
    @(negedge clk);
    a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
    sb.push_back({8'h30, 1'b0, 1'b0});
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; a = 8'hAA; b = 8'h55;
    @(posedge clk);
    #1 start = 1'b0; a = 8'h77; b = 8'h99; sub = 1'b1;
    repeat (25) @(negedge clk);
    chk("ignored_start_drained", sb.size(), 0);
    // asynchronous reset mid-run discards the operation
    @(negedge clk);
    a = 8'h0F; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_result", result, 0);
    chk("async_rst_flags", {busy, done, c_out, overflow}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (15) @(negedge clk);
    op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    // start held high: acceptance every 9 cycles
    @(negedge clk);
    for (int k = 0; k < 9 * 1000; k++) begin
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); start = 1'b1;
      if (k % 9 == 0) sb.push_back(model(a, b, sub));
      @(negedge clk);
      chk("b2b_busy", busy, (k % 9) < 8);
      chk("b2b_done", done, (k % 9) == 8);
    end
    start = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
